// File: rtl/qcom_rx_pkg.sv
// Shared opcode/state types and decode helpers for the QCOM receive deframer.
// Build option QCOM_RX_PARITY_EN adds a trailing XOR parity nibble to every frame.
package qcom_rx_pkg;

    localparam logic [3:0] IDLE_NIB = 4'h0;

    typedef enum logic [3:0] {
        OP_RSV0    = 4'd0,
        OP_CLR_FLG = 4'd1,
        OP_SET_FLG = 4'd2,
        OP_SYNC    = 4'd3,
        OP_D8_DT1  = 4'd4,
        OP_D8_DT2  = 4'd5,
        OP_D16_DT1 = 4'd6,
        OP_D16_DT2 = 4'd7,
        OP_D32_DT1 = 4'd8,
        OP_D32_DT2 = 4'd9
    } qcom_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_PAY  = 3'd2,
        ST_DONE = 3'd3,
        ST_GAP  = 3'd4
`ifdef QCOM_RX_PARITY_EN
        , ST_PAR = 3'd5
`endif
    } qcom_rx_state_t;

    function automatic logic [3:0] op_nibbles(input qcom_op_t op);
        case (op)
            OP_D8_DT1,  OP_D8_DT2:  op_nibbles = 4'd2;
            OP_D16_DT1, OP_D16_DT2: op_nibbles = 4'd4;
            OP_D32_DT1, OP_D32_DT2: op_nibbles = 4'd8;
            default:                op_nibbles = 4'd0;
        endcase
    endfunction

    function automatic logic op_reserved(input qcom_op_t op);
        case (op)
            OP_CLR_FLG, OP_SET_FLG, OP_SYNC,
            OP_D8_DT1, OP_D8_DT2, OP_D16_DT1, OP_D16_DT2,
            OP_D32_DT1, OP_D32_DT2: op_reserved = 1'b0;
            default:                op_reserved = 1'b1;
        endcase
    endfunction

    function automatic logic op_to_dt2(input qcom_op_t op);
        case (op)
            OP_D8_DT2, OP_D16_DT2, OP_D32_DT2: op_to_dt2 = 1'b1;
            default:                           op_to_dt2 = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] par_update(input logic [3:0] par, input logic [3:0] nib);
        par_update = par ^ nib;
    endfunction

endpackage

// File: rtl/qcom_rx_sync.sv
// Synchronizes the link nibble into t_clk and flags the idle->active start edge.
// An edge only counts once a genuine idle sample has passed through the chain after reset.
module qcom_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       t_clk,
    input  logic       t_rst,
    input  logic [3:0] pmod_i,
    output logic [3:0] ln_o,
    output logic       start_o
);
    import qcom_rx_pkg::*;

    logic [3:0]             chain_q [SYNC_STAGES];
    logic [3:0]             chain_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [SYNC_STAGES-1:0] fill_d;
    logic                   prev_idle_q;
    logic                   prev_idle_d;
    logic                   ln_valid_s;

    assign ln_o       = chain_q[SYNC_STAGES-1];
    assign ln_valid_s = fill_q[SYNC_STAGES-1];
    assign start_o    = prev_idle_q && ln_valid_s && (ln_o != IDLE_NIB);

    // Next-state of the synchronizer chain, fill tracker and idle history
    always_comb begin
        chain_d[0] = pmod_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        prev_idle_d = ln_valid_s && (ln_o == IDLE_NIB);
    end

    // Synchronizer registers
    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= 4'h0;
            end
            fill_q      <= {SYNC_STAGES{1'b0}};
            prev_idle_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_d[i];
            end
            fill_q      <= fill_d;
            prev_idle_q <= prev_idle_d;
        end
    end

endmodule

// File: rtl/qcom_rx_deframer.sv
// QCOM link receive deframer: header decode, mid-symbol sampling, payload assembly.
// Define QCOM_RX_PARITY_EN to expect and check a trailing XOR parity nibble per frame.
module qcom_rx_deframer #(
    parameter int SYNC_STAGES = 2,
    parameter int CFG_W       = 4
) (
    input  logic             t_clk,
    input  logic             t_rst,
    input  logic [3:0]       pmod_i,
    input  logic [CFG_W-1:0] cfg_i,
    output logic [31:0]      dt1_o,
    output logic [31:0]      dt2_o,
    output logic             flag_o,
    output logic             vld_o,
    output logic             sync_o,
    output logic             err_o,
    output logic             busy_o
);
    import qcom_rx_pkg::*;

    localparam int            LW   = CFG_W + 1;
    localparam logic [LW-1:0] LONE = {{CFG_W{1'b0}}, 1'b1};
    localparam logic [LW-1:0] LZRO = {LW{1'b0}};

    logic [3:0]     ln_s;
    logic           start_s;
    qcom_rx_state_t state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [3:0]     k_q, k_d;
    logic [31:0]    acc_q, acc_d;
    qcom_op_t       op_q, op_d;
    logic [31:0]    dt1_q, dt1_d;
    logic [31:0]    dt2_q, dt2_d;
    logic           flag_q, flag_d;
    logic           vld_q, vld_d;
    logic           sync_q, sync_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
`ifdef QCOM_RX_PARITY_EN
    logic [3:0]     par_q, par_d;
`endif
    logic           samp_s;
    logic           hdr_go_s;
    logic           ctl_go_s;
    logic           wr_go_s;
    qcom_op_t       hdr_op_s;
    qcom_op_t       ctl_op_s;
    logic [3:0]     hdr_n_s;
    logic [31:0]    wr_data_s;

    qcom_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .t_clk   (t_clk),
        .t_rst   (t_rst),
        .pmod_i  (pmod_i),
        .ln_o    (ln_s),
        .start_o (start_s)
    );

    assign samp_s   = (cnt_q == (len_q >> 1));
    assign hdr_op_s = qcom_op_t'(ln_s);
    assign hdr_n_s  = op_nibbles(hdr_op_s);

    // Frame FSM next-state, payload assembly and output actions
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        k_d       = k_q;
        acc_d     = acc_q;
        op_d      = op_q;
        dt1_d     = dt1_q;
        dt2_d     = dt2_q;
        flag_d    = flag_q;
        vld_d     = 1'b0;
        sync_d    = 1'b0;
        err_d     = 1'b0;
`ifdef QCOM_RX_PARITY_EN
        par_d     = par_q;
`endif
        hdr_go_s  = 1'b0;
        ctl_go_s  = 1'b0;
        wr_go_s   = 1'b0;
        ctl_op_s  = op_q;
        wr_data_s = acc_q;
        if (cnt_q == len_q - LONE) begin
            cnt_d = LZRO;
        end else begin
            cnt_d = cnt_q + LONE;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = LZRO;
                if (start_s) begin
                    len_d = {1'b0, cfg_i} + LONE;
                    acc_d = 32'h0;
                    // With one-cycle symbols the start cycle is the header's only sample.
                    if (cfg_i == {CFG_W{1'b0}}) begin
                        hdr_go_s = 1'b1;
                    end else begin
                        cnt_d   = LONE;
                        state_d = ST_HDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (samp_s) begin
                    hdr_go_s = 1'b1;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAY: begin
                if (samp_s) begin
                    acc_d = {acc_q[27:0], ln_s};
                    k_d   = k_q - 4'd1;
`ifdef QCOM_RX_PARITY_EN
                    par_d = par_update(par_q, ln_s);
`endif
                    if (k_q == 4'd1) begin
`ifdef QCOM_RX_PARITY_EN
                        state_d = ST_PAR;
`else
                        wr_go_s   = 1'b1;
                        wr_data_s = {acc_q[27:0], ln_s};
                        state_d   = ST_DONE;
`endif
                    end else begin
                        state_d = ST_PAY;
                    end
                end else begin
                    state_d = ST_PAY;
                end
            end
`ifdef QCOM_RX_PARITY_EN
            ST_PAR: begin
                if (samp_s) begin
                    if (ln_s != par_q) begin
                        err_d   = 1'b1;
                        state_d = ST_GAP;
                    end else if (op_nibbles(op_q) == 4'd0) begin
                        ctl_go_s = 1'b1;
                        state_d  = ST_GAP;
                    end else begin
                        wr_go_s = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_PAR;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (ln_s == IDLE_NIB) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (hdr_go_s) begin
            op_d = hdr_op_s;
            k_d  = hdr_n_s;
`ifdef QCOM_RX_PARITY_EN
            par_d = ln_s;
`endif
            if (op_reserved(hdr_op_s)) begin
                err_d   = 1'b1;
                state_d = ST_GAP;
            end else if (hdr_n_s == 4'd0) begin
`ifdef QCOM_RX_PARITY_EN
                state_d = ST_PAR;
`else
                ctl_go_s = 1'b1;
                ctl_op_s = hdr_op_s;
                state_d  = ST_GAP;
`endif
            end else begin
                state_d = ST_PAY;
            end
        end else begin
            op_d = op_d;
        end

        // Output registers load here so vld/flag/sync appear one cycle after the deciding sample.
        if (wr_go_s) begin
            vld_d = 1'b1;
            if (op_to_dt2(op_q)) begin
                dt2_d = wr_data_s;
            end else begin
                dt1_d = wr_data_s;
            end
        end else begin
            vld_d = 1'b0;
        end

        if (ctl_go_s) begin
            case (ctl_op_s)
                OP_CLR_FLG: flag_d = 1'b0;
                OP_SET_FLG: flag_d = 1'b1;
                OP_SYNC:    sync_d = 1'b1;
                default:    flag_d = flag_q;
            endcase
        end else begin
            sync_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge t_clk or posedge t_rst) begin
        if (t_rst) begin
            state_q <= ST_IDLE;
            len_q   <= LONE;
            cnt_q   <= LZRO;
            k_q     <= 4'd0;
            acc_q   <= 32'h0;
            op_q    <= OP_RSV0;
            dt1_q   <= 32'h0;
            dt2_q   <= 32'h0;
            flag_q  <= 1'b0;
            vld_q   <= 1'b0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef QCOM_RX_PARITY_EN
            par_q   <= 4'h0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            dt1_q   <= dt1_d;
            dt2_q   <= dt2_d;
            flag_q  <= flag_d;
            vld_q   <= vld_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef QCOM_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign dt1_o  = dt1_q;
    assign dt2_o  = dt2_q;
    assign flag_o = flag_q;
    assign vld_o  = vld_q;
    assign sync_o = sync_q;
    assign err_o  = err_q;
    assign busy_o = busy_q;

endmodule
